inst_mem: RTL and testbench

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem_pkg.sv | 21 ++
 rtl/inst_byte_pack.sv | 33 +++
 rtl/inst_mem.sv | 109 ++++++++++
 tb/tb_inst_mem.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared constants, state encoding and helpers for the instruction memory and its loader.
package inst_mem_pkg;

  localparam int unsigned InstAddrW   = 32;
  localparam int unsigned InstW       = 32;
  localparam int unsigned AddrWDefault = 10;

  // Fetches that cannot be served return this word.
  localparam logic [InstW-1:0] NopInst = 32'h0000_0000;

  typedef enum logic {
    StIdle = 1'b0,
    StLoad = 1'b1
  } state_e;

  // Big-endian assembly: earlier bytes sit in the upper lanes.
  function automatic logic [InstW-1:0] be_word(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/inst_byte_pack.sv
// Serial byte to 32-bit word assembler; strobes word_done on the edge carrying the 4th byte.
module inst_byte_pack
  import inst_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             accept,
  input  logic [7:0]       data,
  output logic [InstW-1:0] word,
  output logic             word_done
);

  logic [1:0]  count_q;
  logic [23:0] shift_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= 2'd0;
      shift_q <= 24'h0;
    end else if (accept) begin
      count_q <= (count_q == 2'd3) ? 2'd0 : count_q + 2'd1;
      // Stale lanes after a completed word are pushed out by the next three bytes.
      shift_q <= {shift_q[15:0], data};
    end
  end

  always_comb begin
    word      = be_word(shift_q, data);
    word_done = accept && (count_q == 2'd3);
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with combinational fetch port and a serial big-endian image loader.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [InstAddrW-1:0] addr,
  output logic [InstW-1:0]     inst,
  input  logic                 load_start,
  input  logic [ADDR_W-1:0]    load_base,
  input  logic [ADDR_W:0]      load_len,
  input  logic [7:0]           load_byte,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 load_done,
  output logic                 busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [InstW-1:0] mem [Depth];

  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              load_done_q;

  logic              accept;
  logic              pack_clr;
  logic [InstW-1:0]  pack_word;
  logic              word_done;

  logic [ADDR_W-1:0] fetch_idx;
  logic              in_range;

  assign accept   = load_valid && (state_q == StLoad);
  // A fresh load always starts assembling at byte 0.
  assign pack_clr = (state_q == StIdle) && load_start;

  inst_byte_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .accept    (accept),
    .data      (load_byte),
    .word      (pack_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      remaining_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            if (load_len == '0) begin
              load_done_q <= 1'b1;
            end else begin
              state_q     <= StLoad;
              wptr_q      <= load_base;
              remaining_q <= load_len;
            end
          end
        end
        StLoad: begin
          if (word_done) begin
            wptr_q      <= wptr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
              state_q     <= StIdle;
              load_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is deliberately not reset so a reset mid-load keeps finished words.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StLoad) && word_done) begin
      mem[wptr_q] <= pack_word;
    end
  end

  always_comb begin
    fetch_idx = addr[ADDR_W+1:2];
    in_range  = (addr >> (ADDR_W + 2)) == '0;
    if (!rst && (state_q == StIdle) && ce && in_range) begin
      inst = mem[fetch_idx];
    end else begin
      inst = NopInst;
    end
  end

  assign load_ready = (state_q == StLoad);
  assign busy       = (state_q == StLoad);
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_inst_mem.sv
// Randomized bench for inst_mem with a queue-based loader model and per-cycle output checks.
module tb_inst_mem;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   inst;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_len = '0;
  logic [7:0]    load_byte = '0;
  logic          load_valid = 1'b0;
  logic          load_ready, load_done, busy;

  inst_mem #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_byte  (load_byte),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a byte queue feeding a list of target word indices.
  logic [31:0] mm [DEPTH];
  bit          known [DEPTH];
  logic [7:0]  mb [$];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_ptr = 0;
  int          m_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit nd;
    nd = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_left = 0;
      m_ptr  = 0;
      mb.delete();
    end else if (!m_busy) begin
      if (load_start) begin
        if (load_len == 0) nd = 1'b1;
        else begin
          m_busy = 1'b1;
          m_ptr  = int'(load_base);
          m_left = int'(load_len);
          mb.delete();
        end
      end
    end else if (load_valid) begin
      mb.push_back(load_byte);
      if (mb.size() == 4) begin
        mm[m_ptr]    = {mb[0], mb[1], mb[2], mb[3]};
        known[m_ptr] = 1'b1;
        m_ptr        = (m_ptr + 1) % DEPTH;
        m_left--;
        mb.delete();
        if (m_left == 0) begin
          m_busy = 1'b0;
          nd     = 1'b1;
        end
      end
    end
    m_done = nd;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      bit hi_zero;
      idx     = int'(addr[AW+1:2]);
      hi_zero = (addr / (32'd4 * DEPTH)) == 0;
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("load_ready", {31'd0, load_ready}, {31'd0, m_busy});
      chk("load_done", {31'd0, load_done}, {31'd0, m_done});
      if (rst || m_busy || !ce || !hi_zero) chk("inst_nop", inst, 32'h0);
      else if (known[idx]) chk("inst_fetch", inst, mm[idx]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int base, input int len);
    load_start = 1'b1;
    load_base  = AW'(base);
    load_len   = (AW + 1)'(len);
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic fetch_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce   = 1'b1;
    addr = a;
    @(negedge clk);
    chk(name, inst, exp);
    #1;
  endtask

  logic [7:0] img [8];

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    img[0] = 8'h3C; img[1] = 8'h01; img[2] = 8'h12; img[3] = 8'h34;
    img[4] = 8'h20; img[5] = 8'h21; img[6] = 8'h00; img[7] = 8'h05;

    // Reset state
    rst = 1'b1;
    ce = 1'b1;
    addr = 32'h0;
    tick(); tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_inst", inst, 32'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    #1;

    // Back-to-back two-word load
    start(0, 2);
    for (int i = 0; i < 8; i++) send(img[i]);
    @(negedge clk);
    chk("b2b_done", {31'd0, load_done}, 32'd1);
    #1;
    fetch_lit("b2b_w0", 32'h0, 32'h3C011234);
    fetch_lit("b2b_w1", 32'h4, 32'h20210005);
    fetch_lit("ignore_lsb", 32'h7, 32'h20210005);

    // Same image with load_valid toggling
    start(0, 2);
    for (int i = 0; i < 8; i++) begin
      send(img[i]);
      if (i != 7) begin
        @(negedge clk);
        chk("toggle_ready", {31'd0, load_ready}, 32'd1);
        chk("toggle_inst", inst, 32'h0);
        #1;
        tick();
      end
    end
    @(negedge clk);
    chk("toggle_done", {31'd0, load_done}, 32'd1);
    #1;
    fetch_lit("toggle_w1", 32'h4, 32'h20210005);

    // Reset after six bytes of a two-word load
    start(0, 2);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    #1;
    fetch_lit("rstmid_w0", 32'h0, 32'h11223344);
    fetch_lit("rstmid_w1", 32'h4, 32'h20210005);
    start(0, 1);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    fetch_lit("clean_w0", 32'h0, 32'hAABBCCDD);

    // Wrap-around and out-of-range fetch
    start(DEPTH - 1, 2);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    fetch_lit("wrap_top", 32'hFFC, 32'hDEADBEEF);
    fetch_lit("wrap_zero", 32'h0, 32'h01020304);
    fetch_lit("out_range", 32'h1000, 32'h0);

    // Zero-length load
    start(3, 0);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("len0_done", {31'd0, load_done}, 32'd1);
    #1;

    // load_start during an active load is ignored
    start(5, 1);
    send(8'hCA);
    load_start = 1'b1; load_base = AW'(9); load_len = (AW + 1)'(3);
    tick();
    load_start = 1'b0;
    send(8'hFE); send(8'hBA);
    send(8'hBE);
    @(negedge clk);
    chk("ign_done", {31'd0, load_done}, 32'd1);
    #1;
    fetch_lit("ign_w5", 32'h14, 32'hCAFEBABE);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int lim;
      for (int k = 0; k < int'($urandom_range(4, 1)); k++) begin
        ce   = ($urandom_range(7, 0) != 0);
        addr = {20'h0, 10'($urandom_range(15, 0)), 2'($urandom)};
        if ($urandom_range(9, 0) == 0) addr[31:12] = 20'($urandom);
        tick();
      end
      if ($urandom_range(19, 0) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      start(int'($urandom_range(15, 0)), int'($urandom_range(4, 0)));
      lim = 0;
      while (m_busy && lim < 300) begin
        load_valid = $urandom_range(1, 0) == 1;
        load_byte  = 8'($urandom);
        ce         = $urandom_range(1, 0) == 1;
        addr       = 32'($urandom_range(63, 0));
        load_start = $urandom_range(9, 0) == 0;
        load_base  = AW'($urandom);
        load_len   = (AW + 1)'($urandom_range(3, 0));
        if ($urandom_range(99, 0) == 0) rst = 1'b1;
        tick();
        rst        = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        lim++;
      end
      if (lim >= 300) begin
        n_bad++;
        $display("FAIL load_timeout at %0t: still busy after %0d cycles, required completion", $time,
                 lim);
      end
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
